// File: rtl/sync_fifo_reader.sv
// Read-side burst controller for sync_fifo: issues rd_en, absorbs the one-cycle
// read latency and streams words out through a 2-entry skid buffer.
module sync_fifo_reader #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_pending;
    logic [1:0]          r_count;
    logic [DATA_W-1:0]   r_buf0;
    logic [DATA_W-1:0]   r_buf1;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_pop;
    logic                w_push;
    logic                w_rd_en;
    logic [2:0]          w_occ;

    assign w_pop  = m_valid & m_ready;
    assign w_push = r_pending;
    // Occupancy the buffer will have once the in-flight word lands and any pop retires.
    assign w_occ  = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};

    assign w_rd_en    = (r_state == ST_RUN) & ~fifo_empty &
                        (r_remaining != {LEN_W{1'b0}}) & (w_occ < 3'd2);
    assign fifo_rd_en = w_rd_en;
    assign m_valid    = (r_count != 2'd0);
    assign m_data     = r_buf0;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

    // Next-state and completion-pulse decode.
    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && (burst_len != {LEN_W{1'b0}})) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_remaining == {LEN_W{1'b0}}) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (!r_pending && (r_count == 2'd0)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, burst counter, in-flight flag, done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= {LEN_W{1'b0}};
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_pending <= w_rd_en;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
                r_remaining <= burst_len;
            end else if (w_rd_en) begin
                r_remaining <= r_remaining - {{(LEN_W-1){1'b0}}, 1'b1};
            end else begin
                r_remaining <= r_remaining;
            end
        end
    end

    // Skid buffer: buf0 is the head; capture and pop in one cycle keep order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= 2'd0;
            r_buf0  <= {DATA_W{1'b0}};
            r_buf1  <= {DATA_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0 <= fifo_data;
                    end else begin
                        r_buf1 <= fifo_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_buf0  <= r_buf1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_buf0 <= fifo_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data;
                    end
                    r_count <= r_count;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader with a behavioural sync_fifo model and
// a handshake log; expected words and timings are hand-derived.
module tb_sync_fifo_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] burst_len;
    logic       fifo_empty;
    logic [3:0] fifo_data = 4'd0;
    logic       fifo_rd_en;
    logic       m_valid;
    logic [3:0] m_data;
    logic       m_ready;
    logic       busy;
    logic       done;

    logic       push_en;
    logic [3:0] push_val;
    logic       fifo_flush;
    logic       log_clr;
    logic [3:0] mem [64];
    logic [3:0] got [32];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         n_got  = 0;
    int         n_done = 0;
    int         n_total = 0;
    int         n_bad   = 0;

    sync_fifo_reader #(.DATA_W(4), .LEN_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    // sync_fifo model: registered data_out one cycle after an accepted read.
    always @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr % 64] <= push_val;
            wr_ptr <= wr_ptr + 1;
        end
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Handshake and done-pulse log.
    always @(posedge clk) begin
        if (log_clr) begin
            n_got  <= 0;
            n_done <= 0;
        end else begin
            if (m_valid && m_ready && n_got < 32) begin
                got[n_got] <= m_data;
                n_got <= n_got + 1;
            end
            if (done) begin
                n_done <= n_done + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_total++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [3:0] v);
        push_en  = 1'b1;
        push_val = v;
        @(negedge clk);
        push_en  = 1'b0;
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        @(negedge clk);
        log_clr = 1'b0;
    endtask

    task automatic clear_all();
        fifo_flush = 1'b1;
        log_clr    = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        log_clr    = 1'b0;
    endtask

    task automatic kick(input logic [3:0] len);
        start     = 1'b1;
        burst_len = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int gap  = 0;
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) gap++;
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_busy_held"}, gap, 32'd0);
    endtask

    task automatic check_log(input string tag, input logic [31:0] exp_words, input int n);
        chk({tag, "_count"}, n_got, n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_word"}, 32'(got[i]), 32'(exp_words[i*4 +: 4]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit         prev_stall;
        logic [3:0] prev_data;
        bit         seen;

        reset = 1'b0; start = 1'b0; burst_len = 4'd0; m_ready = 1'b0;
        push_en = 1'b0; push_val = 4'd0; fifo_flush = 1'b0; log_clr = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        reset = 1'b1;
        step();

        // 1: four-word burst with free-flowing consumer, exact timing.
        clear_all();
        for (int i = 0; i < 4; i++) push_word(4'(i));
        m_ready = 1'b1;
        kick(4'd4);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("t1_v_e0", 32'(m_valid), 32'd0);
        step();
        chk("t1_v_e1", 32'(m_valid), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t1_valid", 32'(m_valid), 32'd1);
            chk("t1_data", 32'(m_data), 32'(k));
        end
        step();
        chk("t1_v_end", 32'(m_valid), 32'd0);
        chk("t1_done_early", 32'(done), 32'd0);
        chk("t1_busy_flush", 32'(busy), 32'd1);
        step();
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done), 32'd0);
        check_log("t1_log", 32'h0000_3210, 4);
        chk("t1_ndone", n_done, 32'd1);
        chk("t1_level", wr_ptr - rd_ptr, 32'd0);

        // 2: stalled consumer, buffer fills to two then issue stops.
        clear_all();
        m_ready = 1'b0;
        for (int i = 5; i < 10; i++) push_word(4'(i));
        kick(4'd3);
        chk("t2_rd_e0", 32'(fifo_rd_en), 32'd1);
        step();
        chk("t2_rd_e1", 32'(fifo_rd_en), 32'd1);
        step();
        chk("t2_rd_e2", 32'(fifo_rd_en), 32'd0);
        chk("t2_head_e2", 32'(m_data), 32'd5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_stall_v", 32'(m_valid), 32'd1);
            chk("t2_stall_d", 32'(m_data), 32'd5);
            chk("t2_stall_rd", 32'(fifo_rd_en), 32'd0);
        end
        chk("t2_level_stall", wr_ptr - rd_ptr, 32'd3);
        m_ready = 1'b1;
        wait_done("t2", 20);
        step();
        check_log("t2_log", 32'h0000_0765, 3);
        chk("t2_level", wr_ptr - rd_ptr, 32'd2);
        chk("t2_ndone", n_done, 32'd1);

        // 3: FIFO underflow mid-burst pauses issue.
        clear_all();
        m_ready = 1'b1;
        push_word(4'hA);
        kick(4'd4);
        chk("t3_rd_e0", 32'(fifo_rd_en), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_rd_paused", 32'(fifo_rd_en), 32'd0);
            chk("t3_busy", 32'(busy), 32'd1);
        end
        push_word(4'hB);
        chk("t3_resume", 32'(fifo_rd_en), 32'd1);
        push_word(4'hC);
        push_word(4'hD);
        wait_done("t3", 30);
        step();
        check_log("t3_log", 32'h0000_DCBA, 4);
        chk("t3_ndone", n_done, 32'd1);

        // 4: alternating backpressure over an eight-word burst.
        clear_all();
        for (int i = 8; i < 16; i++) push_word(4'(i));
        m_ready = 1'b1;
        kick(4'd8);
        prev_stall = 1'b0;
        prev_data  = 4'd0;
        seen       = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (prev_stall) begin
                chk("t4_hold_v", 32'(m_valid), 32'd1);
                chk("t4_hold_d", 32'(m_data), 32'(prev_data));
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            m_ready    = (i % 2 == 1);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            step();
        end
        chk("t4_done_seen", 32'(seen), 32'd1);
        m_ready = 1'b1;
        step();
        check_log("t4_log", 32'hFEDC_BA98, 8);
        chk("t4_ndone", n_done, 32'd1);

        // 5: reset mid-burst, then a fresh two-word burst.
        clear_all();
        for (int i = 1; i < 7; i++) push_word(4'(i));
        m_ready = 1'b1;
        kick(4'd6);
        for (int i = 0; i < 20; i++) begin
            if (n_got >= 2) break;
            step();
        end
        chk("t5_two_seen", n_got, 32'd2);
        reset = 1'b0;
        step();
        chk("t5_rst_v", 32'(m_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        chk("t5_rst_rd", 32'(fifo_rd_en), 32'd0);
        chk("t5_level", wr_ptr - rd_ptr, 32'd1);
        reset = 1'b1;
        clear_log();
        push_word(4'd7);
        kick(4'd2);
        wait_done("t5", 20);
        step();
        check_log("t5_log", 32'h0000_0076, 2);
        chk("t5_ndone", n_done, 32'd1);

        // 6: zero-length start and start while busy are both ignored.
        clear_all();
        push_word(4'd3);
        push_word(4'd4);
        m_ready = 1'b1;
        kick(4'd0);
        chk("t6_zero_busy", 32'(busy), 32'd0);
        step();
        step();
        chk("t6_zero_idle", 32'(busy), 32'd0);
        chk("t6_zero_rd", 32'(fifo_rd_en), 32'd0);
        chk("t6_zero_ndone", n_done, 32'd0);
        chk("t6_zero_level", wr_ptr - rd_ptr, 32'd2);
        m_ready = 1'b0;
        kick(4'd2);
        chk("t6_busy", 32'(busy), 32'd1);
        step();
        start = 1'b1;
        burst_len = 4'd5;
        step();
        start = 1'b0;
        chk("t6_busy_restart", 32'(busy), 32'd1);
        m_ready = 1'b1;
        wait_done("t6", 20);
        repeat (6) step();
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_ndone", n_done, 32'd1);
        check_log("t6_log", 32'h0000_0043, 2);
        chk("t6_level", wr_ptr - rd_ptr, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
